hazard_ctrl: RTL
================

# hazard_ctrl

Central hazard and forwarding controller for the five-stage MIPS pipeline. It keeps a small scoreboard of destination register and remaining Tnew for the instructions in E, M and W. From that scoreboard and the Tuse of the instruction in D, it computes each cycle:
- the stall request;
- the 2-bit select codes that drive the D, E and M forwarding muxes.
It also sequences the multi-cycle multiply/divide unit with a busy counter.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: MDU busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: MDU busy cycles for div/divu.

Ports:
- `hazard_ctrl_i_clk` input, 1: clock, rising edge.
- `hazard_ctrl_i_reset` input, 1: synchronous, active-high reset.
- `hazard_ctrl_i_flush` input, 1: exception/eret flush, synchronous.
- `hazard_ctrl_i_D_rs` / `hazard_ctrl_i_D_rt` input, 5 each: source registers of the D instruction.
- `hazard_ctrl_i_D_TuseRs` / `hazard_ctrl_i_D_TuseRt` input, 2 each: Tuse 0..2; 3 = not used.
- `hazard_ctrl_i_D_dst` input, 5: destination register; 0 = no write.
- `hazard_ctrl_i_D_Tnew` input, 2: Tnew counted at E entry (ALU 1, load 2, jal 0).
- `hazard_ctrl_i_D_mdStart` input, 1: D instruction is mult/multu/div/divu.
- `hazard_ctrl_i_D_mdIsDiv` input, 1: with mdStart, 1 = div class.
- `hazard_ctrl_i_D_mdUse` input, 1: D instruction is mfhi/mflo/mthi/mtlo or an MDU start.
- `hazard_ctrl_o_stall` output, 1: freeze PC and the F/D register; insert a bubble into E.
- `hazard_ctrl_o_fwdDRs` / `hazard_ctrl_o_fwdDRt` output, 2 each: D mux select (00 none, 01 E register, 10 M register).
- `hazard_ctrl_o_fwdERs` / `hazard_ctrl_o_fwdERt` output, 2 each: E mux select (00 none, 01 M register, 10 W register).
- `hazard_ctrl_o_fwdMRt` output, 2: M store-data mux select (00 none, 01 W register).
- `hazard_ctrl_o_mdBusy` output, 1: MDU counter is non-zero.

## Operation
Scoreboard:
- Entries are E, M and W, each holding {dst, Tnew}. E and M also hold {rs, rt}.
- A bubble is dst=0, Tnew=0, rs=rt=0.

Advance, on each edge outside reset/flush:
- E is loaded with the D info, or with a bubble if the stall is asserted.
- M is loaded from E, with Tnew = max(E.Tnew−1, 0).
- W is loaded from M, with Tnew = max(M.Tnew−1, 0).

Match rule:
- Source s matches entry X when s≠0 and s==X.dst.

Stall (combinational):
- Stall if any used source s (Tuse≠3) matches E with E.Tnew > Tuse.
- Stall if s matches M with M.Tnew > Tuse.
- With the MDU feature: also stall if mdUse=1 and the MDU counter≠0.

D forwarding, nearest stage first:
- If s matches E and E.Tnew==0: select 01.
- Else if s matches M and M.Tnew==0: select 10.
- Else: select 00. The W→D path is handled inside the GRF and is never selected here.

E forwarding, using the E.rs/E.rt entry:
- If s matches M and M.Tnew==0: select 01.
- Else if s matches W: select 10.
- Else: select 00.

M forwarding:
- If M.rt matches W: fwdMRt = 01.
- Else: 00.

MDU counter:
- On an edge where D advances (no stall, no flush) with mdStart=1, the counter loads DIV_CYCLES if mdIsDiv=1, else MULT_CYCLES.
- Otherwise it decrements while non-zero.
- mdBusy = (counter≠0).

Flush:
- E, M and W all become bubbles.
- The MDU counter keeps counting.
- The D info is discarded.

## Timing
- All outputs are combinational from the scoreboard and D inputs, so they are valid in the same cycle.
- The scoreboard updates on the rising edge.
- Reset: every entry becomes a bubble and the counter becomes 0. While reset is high, stall=0, all fwd outputs = 00 and mdBusy=0.
- Flush and stall in the same cycle: flush wins, the stall output is forced to 0, and E receives a bubble.
- Reset and flush together: reset wins.
- Flush is ignored in the reset cycle.
- mdStart on a stalled cycle does not load the counter. It loads on the edge where the instruction actually enters E.
- A load followed by a dependent ALU op (Tuse 1) stalls for exactly 1 cycle.
- A load followed by a beq that depends on it (Tuse 0) stalls for 2 cycles.
- Counter wrap: it saturates at 0 and never underflows.
- A new mdStart while the counter≠0 stalls, because mdUse is also 1.

## Configuration
- `HAZARD_MDU_EN` defined: the MDU counter, mdBusy and the MDU stall term are compiled in.
- `HAZARD_MDU_EN` undefined:
  - mdStart, mdIsDiv and mdUse are ignored;
  - mdBusy is tied to 0;
  - no counter register exists;
  - the stall is determined by register hazards only.

## Test plan
- `lw $1` then `addu $2,$1,$3` (Tuse 1):
  - stall=1 for one cycle;
  - next cycle fwdERs=10 (W);
  - no stall after that.
- `addu $1` then `beq $1,$0` (Tuse 0):
  - stall=1 for one cycle;
  - then fwdDRs=10 (M, Tnew 0).
- `jal` ($31, Tnew 0) then `jr $31`: no stall, fwdDRs=01 (E register).
- `addu $0,$4,$5` then `addu $6,$0,$0`: no stall, all fwd outputs = 00.
- `div`, then `mflo` on the next cycle:
  - mdBusy=1 for 10 cycles;
  - stall=1 for 10 cycles;
  - mflo enters E on the 11th cycle.
  - Without `HAZARD_MDU_EN`: no stall.
- Flush asserted while a `lw $1` is in E:
  - the next cycle's scoreboard is empty;
  - a following `addu $2,$1,$1` sees stall=0 and fwd=00.
  - Reset mid-`mult`: mdBusy=0 the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the five-stage MIPS pipeline: E/M/W scoreboard of {dst, Tnew},
// stall and forwarding selects, plus an optional MDU busy counter compiled in with HAZARD_MDU_EN.
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       hazard_ctrl_i_clk,
   input  logic       hazard_ctrl_i_reset,
   input  logic       hazard_ctrl_i_flush,
   input  logic [4:0] hazard_ctrl_i_D_rs,
   input  logic [4:0] hazard_ctrl_i_D_rt,
   input  logic [1:0] hazard_ctrl_i_D_TuseRs,
   input  logic [1:0] hazard_ctrl_i_D_TuseRt,
   input  logic [4:0] hazard_ctrl_i_D_dst,
   input  logic [1:0] hazard_ctrl_i_D_Tnew,
   input  logic       hazard_ctrl_i_D_mdStart,
   input  logic       hazard_ctrl_i_D_mdIsDiv,
   input  logic       hazard_ctrl_i_D_mdUse,
   output logic       hazard_ctrl_o_stall,
   output logic [1:0] hazard_ctrl_o_fwdDRs,
   output logic [1:0] hazard_ctrl_o_fwdDRt,
   output logic [1:0] hazard_ctrl_o_fwdERs,
   output logic [1:0] hazard_ctrl_o_fwdERt,
   output logic [1:0] hazard_ctrl_o_fwdMRt,
   output logic       hazard_ctrl_o_mdBusy
);

   localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W  = $clog2(MD_MAX + 1);

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] e_dst,
      input logic [1:0] e_tnew,
      input logic [4:0] m_dst,
      input logic [1:0] m_tnew
   );
      logic late_e;
      logic late_m;
      late_e = hit(src, e_dst) && (e_tnew > tuse);
      late_m = hit(src, m_dst) && (m_tnew > tuse);
      return (tuse != 2'd3) && (late_e || late_m);
   endfunction

   // W never feeds D here: the register file writes first and reads second.
   function automatic logic [1:0] fwd_d_sel(
      input logic [4:0] src,
      input logic [4:0] e_dst,
      input logic [1:0] e_tnew,
      input logic [4:0] m_dst,
      input logic [1:0] m_tnew
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (hit(src, e_dst) && (e_tnew == 2'd0)) begin
         sel = 2'b01;
      end else if (hit(src, m_dst) && (m_tnew == 2'd0)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   function automatic logic [1:0] fwd_e_sel(
      input logic [4:0] src,
      input logic [4:0] m_dst,
      input logic [1:0] m_tnew,
      input logic [4:0] w_dst
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (hit(src, m_dst) && (m_tnew == 2'd0)) begin
         sel = 2'b01;
      end else if (hit(src, w_dst)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [4:0] e_dst_q, e_dst_d;
   logic [4:0] e_rs_q, e_rs_d;
   logic [4:0] e_rt_q, e_rt_d;
   logic [1:0] e_tnew_q, e_tnew_d;
   logic [4:0] m_dst_q, m_dst_d;
   logic [4:0] m_rt_q, m_rt_d;
   logic [1:0] m_tnew_q, m_tnew_d;
   logic [4:0] w_dst_q, w_dst_d;
   logic [1:0] w_tnew_q, w_tnew_d;

   logic reg_hazard;
   logic md_stall;
   logic md_busy;
   logic stall_raw;

   always_comb begin
      reg_hazard = 1'b0;
      reg_hazard = src_hazard(hazard_ctrl_i_D_rs, hazard_ctrl_i_D_TuseRs,
                              e_dst_q, e_tnew_q, m_dst_q, m_tnew_q)
                 | src_hazard(hazard_ctrl_i_D_rt, hazard_ctrl_i_D_TuseRt,
                              e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
   end

   assign stall_raw = reg_hazard | md_stall;

   // ---------------------------------------------------------------------------
   // MDU busy counter
   // ---------------------------------------------------------------------------
`ifdef HAZARD_MDU_EN
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

   assign md_busy  = (md_cnt_q != '0);
   assign md_stall = hazard_ctrl_i_D_mdUse && md_busy;

   // Loads only when the start instruction really enters E; flush does not stop the unit.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (!hazard_ctrl_i_flush && !stall_raw && hazard_ctrl_i_D_mdStart) begin
         md_cnt_d = hazard_ctrl_i_D_mdIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge hazard_ctrl_i_clk) begin
      if (hazard_ctrl_i_reset) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end
`else
   logic unused_md_inputs;

   assign md_busy          = 1'b0;
   assign md_stall         = 1'b0;
   assign unused_md_inputs = ^{hazard_ctrl_i_D_mdStart, hazard_ctrl_i_D_mdIsDiv,
                               hazard_ctrl_i_D_mdUse};
`endif

   // ---------------------------------------------------------------------------
   // Scoreboard advance
   // ---------------------------------------------------------------------------
   always_comb begin
      e_dst_d  = hazard_ctrl_i_D_dst;
      e_rs_d   = hazard_ctrl_i_D_rs;
      e_rt_d   = hazard_ctrl_i_D_rt;
      e_tnew_d = hazard_ctrl_i_D_Tnew;
      m_dst_d  = e_dst_q;
      m_rt_d   = e_rt_q;
      m_tnew_d = tnew_dec(e_tnew_q);
      w_dst_d  = m_dst_q;
      w_tnew_d = tnew_dec(m_tnew_q);
      if (hazard_ctrl_i_flush) begin
         e_dst_d  = 5'd0;
         e_rs_d   = 5'd0;
         e_rt_d   = 5'd0;
         e_tnew_d = 2'd0;
         m_dst_d  = 5'd0;
         m_rt_d   = 5'd0;
         m_tnew_d = 2'd0;
         w_dst_d  = 5'd0;
         w_tnew_d = 2'd0;
      end else if (stall_raw) begin
         e_dst_d  = 5'd0;
         e_rs_d   = 5'd0;
         e_rt_d   = 5'd0;
         e_tnew_d = 2'd0;
      end
   end

   always_ff @(posedge hazard_ctrl_i_clk) begin
      if (hazard_ctrl_i_reset) begin
         e_dst_q  <= 5'd0;
         e_rs_q   <= 5'd0;
         e_rt_q   <= 5'd0;
         e_tnew_q <= 2'd0;
         m_dst_q  <= 5'd0;
         m_rt_q   <= 5'd0;
         m_tnew_q <= 2'd0;
         w_dst_q  <= 5'd0;
         w_tnew_q <= 2'd0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         e_tnew_q <= e_tnew_d;
         m_dst_q  <= m_dst_d;
         m_rt_q   <= m_rt_d;
         m_tnew_q <= m_tnew_d;
         w_dst_q  <= w_dst_d;
         w_tnew_q <= w_tnew_d;
      end
   end

   // W's Tnew is kept for scoreboard completeness; every W consumer is already past its Tuse.
   logic unused_w_tnew;
   assign unused_w_tnew = ^w_tnew_q;

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

   always_comb begin
      fwd_d_rs = fwd_d_sel(hazard_ctrl_i_D_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
      fwd_d_rt = fwd_d_sel(hazard_ctrl_i_D_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
      fwd_e_rs = fwd_e_sel(e_rs_q, m_dst_q, m_tnew_q, w_dst_q);
      fwd_e_rt = fwd_e_sel(e_rt_q, m_dst_q, m_tnew_q, w_dst_q);
      fwd_m_rt = hit(m_rt_q, w_dst_q) ? 2'b01 : 2'b00;
   end

   // A flush empties the pipe anyway, so holding D would only lose a cycle.
   assign hazard_ctrl_o_stall  = !hazard_ctrl_i_reset && !hazard_ctrl_i_flush && stall_raw;
   assign hazard_ctrl_o_fwdDRs = hazard_ctrl_i_reset ? 2'b00 : fwd_d_rs;
   assign hazard_ctrl_o_fwdDRt = hazard_ctrl_i_reset ? 2'b00 : fwd_d_rt;
   assign hazard_ctrl_o_fwdERs = hazard_ctrl_i_reset ? 2'b00 : fwd_e_rs;
   assign hazard_ctrl_o_fwdERt = hazard_ctrl_i_reset ? 2'b00 : fwd_e_rt;
   assign hazard_ctrl_o_fwdMRt = hazard_ctrl_i_reset ? 2'b00 : fwd_m_rt;
   assign hazard_ctrl_o_mdBusy = !hazard_ctrl_i_reset && md_busy;

endmodule
